// File: rtl/madd_pipe.sv
// Two-stage multiply-add pipeline with valid/ready handshake on both sides.
// Stage 1 holds the product and extended addend; stage 2 holds the result and updates the accumulator.
module madd_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [1:0]       OP,
   input  logic             SGN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] Z,
   output logic [WIDTH-1:0] ZH,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      OP_MADD   = 2'b00,
      OP_MSUB   = 2'b01,
      OP_MAC    = 2'b10,
      OP_CLRMAC = 2'b11
   } op_e;

   logic          v1_q, v1_d;
   logic [W2-1:0] p1_q, p1_d;
   logic [W2-1:0] cx1_q, cx1_d;
   op_e           op1_q, op1_d;

   logic          v2_q, v2_d;
   logic [W2-1:0] r2_q, r2_d;
   logic [W2-1:0] acc_q, acc_d;

   logic          adv1, adv2;
   logic [W2-1:0] ax, bx, cx, p_in, r_s2;

   assign adv2      = ~v2_q | OUT_READY;
   assign adv1      = ~v1_q | adv2;
   // Reset gating keeps beats offered during reset from looking accepted.
   assign IN_READY  = adv1 & ~RST;
   assign Z         = r2_q[WIDTH-1:0];
   assign ZH        = r2_q[W2-1:WIDTH];
   assign OUT_VALID = v2_q;

   always_comb begin
      ax   = SGN ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
      bx   = SGN ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
      cx   = SGN ? {{WIDTH{C[WIDTH-1]}}, C} : {{WIDTH{1'b0}}, C};
      p_in = ax * bx;
   end

   always_comb begin
      r_s2 = p1_q;
      case (op1_q)
         OP_MADD:   r_s2 = p1_q + cx1_q;
         OP_MSUB:   r_s2 = cx1_q - p1_q;
         OP_MAC:    r_s2 = p1_q + acc_q;
         OP_CLRMAC: r_s2 = p1_q;
         default:   r_s2 = p1_q;
      endcase
   end

   always_comb begin
      v1_d  = v1_q;
      p1_d  = p1_q;
      cx1_d = cx1_q;
      op1_d = op1_q;
      if (adv1) begin
         v1_d = IN_VALID;
         if (IN_VALID) begin
            p1_d  = p_in;
            cx1_d = cx;
            op1_d = op_e'(OP);
         end
      end
   end

   // ACC moves only when a MAC/CLRMAC beat actually lands in stage 2.
   always_comb begin
      v2_d  = v2_q;
      r2_d  = r2_q;
      acc_d = acc_q;
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            r2_d = r_s2;
            if (op1_q == OP_MAC || op1_q == OP_CLRMAC) acc_d = r_s2;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v1_q  <= 1'b0;
         p1_q  <= '0;
         cx1_q <= '0;
         op1_q <= OP_MADD;
         v2_q  <= 1'b0;
         r2_q  <= '0;
         acc_q <= '0;
      end else begin
         v1_q  <= v1_d;
         p1_q  <= p1_d;
         cx1_q <= cx1_d;
         op1_q <= op1_d;
         v2_q  <= v2_d;
         r2_q  <= r2_d;
         acc_q <= acc_d;
      end
   end

endmodule
